// File: rtl/adder_synchronous_pkg.sv
// adder_synchronous_pkg: shared width defaults and result types for the registered adder.
package adder_synchronous_pkg;
   localparam int ADDER_DEFAULT_WIDTH = 2;
   typedef logic [ADDER_DEFAULT_WIDTH:0] result_t;
   function automatic int result_width(input int w);
      return w + 1;
   endfunction
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit full adder cell for the ripple-carry chain.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_synchronous.sv
// adder_synchronous: registered unsigned adder, {Carry_reg,Sum_reg} <= A + B.
// Define ADDER_SYNCHRONOUS_INPUT_REG_EN to register the operands first (2-cycle latency).
module adder_synchronous
   import adder_synchronous_pkg::*;
#(
   parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum_reg,
   output logic             Carry_reg
);
   localparam int RW = result_width(WIDTH);
   logic [WIDTH-1:0] op_a, op_b, s;
   logic [WIDTH:0]   c;
   logic [RW-1:0]    res;
`ifdef ADDER_SYNCHRONOUS_INPUT_REG_EN
   logic [WIDTH-1:0] A_q, B_q;
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         A_q <= '0;
         B_q <= '0;
      end else begin
         A_q <= A;
         B_q <= B;
      end
   assign op_a = A_q;
   assign op_b = B_q;
`else
   assign op_a = A;
   assign op_b = B;
`endif
   assign c[0] = 1'b0;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder_bit u_fa (
         .a(op_a[i]),
         .b(op_b[i]),
         .cin(c[i]),
         .s(s[i]),
         .cout(c[i+1])
      );
   end
   assign res = {c[WIDTH], s};
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) {Carry_reg, Sum_reg} <= '0;
      else        {Carry_reg, Sum_reg} <= res;
endmodule

// File: tb/tb_adder_synchronous.sv
// tb_adder_synchronous: directed vector table plus reset/latency sequences for adder_synchronous.
module tb_adder_synchronous;
`ifdef ADDER_SYNCHRONOUS_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic       Clk = 1'b0;
   logic       Rst_n = 1'b1;
   logic [1:0] A = '0, B = '0, Sum_reg;
   logic       Carry_reg;
   logic [7:0] A8 = '0, B8 = '0, Sum8;
   logic       Carry8;
   int vecs = 0, errs = 0;

   typedef struct {
      string      nm;
      logic [1:0] a, b;
      logic [2:0] exp;
   } vec_t;
   vec_t tbl[19];

   adder_synchronous #(.WIDTH(2)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Sum_reg(Sum_reg), .Carry_reg(Carry_reg)
   );
   adder_synchronous #(.WIDTH(8)) dut8 (
      .Clk(Clk), .Rst_n(Rst_n), .A(A8), .B(B8), .Sum_reg(Sum8), .Carry_reg(Carry8)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %b, expected %b", nm, got, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         v = 4'(i);
         tbl[i].nm  = $sformatf("sweep_%0d", i);
         tbl[i].a   = v[3:2];
         tbl[i].b   = v[1:0];
         tbl[i].exp = {1'b0, v[3:2]} + {1'b0, v[1:0]};
      end
      tbl[16] = '{"carry_3p1", 2'd3, 2'd1, 3'b100};
      tbl[17] = '{"carry_3p3", 2'd3, 2'd3, 3'b110};
      tbl[18] = '{"zero_0p0",  2'd0, 2'd0, 3'b000};

      A = 2'd3; B = 2'd3;
      #1 Rst_n = 1'b0;
      #1 check("reset_async", {6'b0, Carry_reg, Sum_reg}, 9'b0);
      for (int k = 0; k < 3; k++) begin
         edges(1);
         check("reset_hold", {6'b0, Carry_reg, Sum_reg}, 9'b0);
      end
      @(negedge Clk) Rst_n = 1'b1;
      #1 check("release_pre_edge", {6'b0, Carry_reg, Sum_reg}, 9'b0);
      @(negedge Clk);

      for (int i = 0; i < 19; i++) begin
         A = tbl[i].a; B = tbl[i].b;
         edges(LAT);
         check(tbl[i].nm, {6'b0, Carry_reg, Sum_reg}, {6'b0, tbl[i].exp});
      end

      A = 2'd1; B = 2'd1;
      edges(LAT);
      check("hold_base", {6'b0, Carry_reg, Sum_reg}, 9'b010);
      #2 A = 2'd3; B = 2'd2;
      #2 check("hold_mid_cycle", {6'b0, Carry_reg, Sum_reg}, 9'b010);
      edges(1);
      check("hold_next_edge", {6'b0, Carry_reg, Sum_reg}, LAT == 1 ? 9'b101 : 9'b010);
      if (LAT == 2) begin
         edges(1);
         check("hold_second_edge", {6'b0, Carry_reg, Sum_reg}, 9'b101);
      end

      #2 Rst_n = 1'b0;
      #1 check("reset_mid_stream", {6'b0, Carry_reg, Sum_reg}, 9'b0);
      A = 2'd1; B = 2'd1;
      @(negedge Clk) Rst_n = 1'b1;
      edges(LAT);
      check("after_reset_1p1", {6'b0, Carry_reg, Sum_reg}, 9'b010);

      A = 2'd2; B = 2'd3;
      edges(1);
      check("latency_edge_n", {6'b0, Carry_reg, Sum_reg}, LAT == 1 ? 9'b101 : 9'b010);
      edges(1);
      check("latency_edge_n1", {6'b0, Carry_reg, Sum_reg}, 9'b101);

      A8 = 8'd255; B8 = 8'd1;
      edges(LAT);
      check("w8_255p1", {Carry8, Sum8}, 9'h100);
      A8 = 8'd200; B8 = 8'd100;
      edges(LAT);
      check("w8_200p100", {Carry8, Sum8}, 9'd300);
      A8 = 8'd255; B8 = 8'd255;
      edges(LAT);
      check("w8_255p255", {Carry8, Sum8}, 9'h1fe);
      A8 = 8'd18; B8 = 8'd52;
      edges(LAT);
      check("w8_18p52", {Carry8, Sum8}, 9'd70);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
